// File: rtl/forwarding_scoreboard.sv
// Forwarding select and load-use hazard detection from a shadow of in-flight writers (EX..WB).
// Optional FWD_PERF_EN adds saturating stall/forward performance counters.
module forwarding_scoreboard #(
  parameter int REG_ADDR_W      = 2,
  parameter int NUM_SRC         = 2,
  parameter int DEPTH           = 2,
  parameter int LOAD_READY_SLOT = 2,
  parameter int FORWARD_EN      = 1,
  parameter int SEL_W           = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          id_valid,
  input  logic                          id_reg_write,
  input  logic                          id_is_load,
  input  logic [REG_ADDR_W-1:0]         id_dest,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]            id_src_used,
  input  logic                          flush,
  input  logic                          stall_ext,
  output logic                          stall,
  output logic [NUM_SRC*SEL_W-1:0]      fwd_sel
`ifdef FWD_PERF_EN
  ,
  output logic [15:0]                   perf_stall_cnt,
  output logic [15:0]                   perf_fwd_cnt
`endif
);

  localparam logic [SEL_W-1:0] SEL_RF = SEL_W'(DEPTH);

  // slot 0 = EX, slot 1 = MEM, slot DEPTH = WB
  logic [DEPTH:0]                valid_q, valid_d;
  logic [DEPTH:0]                regw_q, regw_d;
  logic [DEPTH:0]                load_q, load_d;
  logic [REG_ADDR_W-1:0]         dest_q [DEPTH+1];
  logic [REG_ADDR_W-1:0]         dest_d [DEPTH+1];
  logic [NUM_SRC*REG_ADDR_W-1:0] src_q, src_d;
  logic [NUM_SRC-1:0]            used_q, used_d;
  logic                          stall_c;
  logic [SEL_W-1:0]              sel_c [NUM_SRC];

  always_comb begin
    stall_c = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int s = 0; s < DEPTH; s++) begin
        if (id_src_used[i] && valid_q[s] && regw_q[s] &&
            dest_q[s] == id_src[i*REG_ADDR_W +: REG_ADDR_W]) begin
          if (FORWARD_EN == 0) stall_c = 1'b1;
          else if (load_q[s] && (s + 1) < LOAD_READY_SLOT) stall_c = 1'b1;
        end
      end
    end
    if (!id_valid || flush) stall_c = 1'b0;
  end

  // Walk from the far slot inward so the nearest matching writer decides.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      sel_c[i] = SEL_RF;
      for (int k = DEPTH; k >= 1; k--) begin
        if (valid_q[k] && regw_q[k] && dest_q[k] == src_q[i*REG_ADDR_W +: REG_ADDR_W]) begin
          if (FORWARD_EN != 0 && (!load_q[k] || k >= LOAD_READY_SLOT)) sel_c[i] = SEL_W'(k - 1);
          else sel_c[i] = SEL_RF;
        end
      end
      if (!used_q[i] || !valid_q[0]) sel_c[i] = SEL_RF;
    end
  end

  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) fwd_sel[i*SEL_W +: SEL_W] = sel_c[i];
  end

  assign stall = stall_c;

  always_comb begin
    valid_d = valid_q;
    regw_d  = regw_q;
    load_d  = load_q;
    dest_d  = dest_q;
    src_d   = src_q;
    used_d  = used_q;
    if (!stall_ext) begin
      for (int k = DEPTH; k >= 1; k--) begin
        valid_d[k] = valid_q[k-1];
        regw_d[k]  = regw_q[k-1];
        load_d[k]  = load_q[k-1];
        dest_d[k]  = dest_q[k-1];
      end
      valid_d[0] = id_valid & ~stall_c & ~flush;
      regw_d[0]  = id_reg_write;
      load_d[0]  = id_is_load;
      dest_d[0]  = id_dest;
      src_d      = id_src;
      used_d     = id_src_used;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      regw_q  <= '0;
      load_q  <= '0;
      for (int k = 0; k <= DEPTH; k++) dest_q[k] <= '0;
      src_q   <= '0;
      used_q  <= '0;
    end else begin
      valid_q <= valid_d;
      regw_q  <= regw_d;
      load_q  <= load_d;
      dest_q  <= dest_d;
      src_q   <= src_d;
      used_q  <= used_d;
    end
  end

`ifdef FWD_PERF_EN
  logic [15:0] perf_stall_q, perf_stall_d;
  logic [15:0] perf_fwd_q, perf_fwd_d;
  logic [16:0] fwd_sum;

  always_comb begin
    perf_stall_d = perf_stall_q;
    fwd_sum      = {1'b0, perf_fwd_q};
    if (!stall_ext) begin
      if (stall_c && perf_stall_q != 16'hFFFF) perf_stall_d = perf_stall_q + 16'd1;
      if (valid_q[0]) begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if (sel_c[i] != SEL_RF) fwd_sum = fwd_sum + 17'd1;
        end
      end
    end
    perf_fwd_d = (fwd_sum > 17'h0FFFF) ? 16'hFFFF : fwd_sum[15:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_stall_q <= '0;
      perf_fwd_q   <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_fwd_q   <= perf_fwd_d;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_fwd_cnt   = perf_fwd_q;
`endif

endmodule
